match_event_logger: RTL and testbench
=====================================

MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 SHALL have parameter POS_W, default 8: width of the bit-position counter and of logged entries.
REQ-002 SHALL have parameter DEPTH, default 4: number of FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of all state.
REQ-007 SHALL have port bit_en  input  1  one serial bit was presented to the 1101 detector this cycle.
REQ-008 SHALL have port tick  input  1  detector match pulse for the bit presented this cycle.
REQ-009 SHALL have port rd_en  input  1  pop request for the FIFO head.
REQ-010 SHALL have port rd_data  output  POS_W  bit position at the FIFO head (first-word-fall-through).
REQ-011 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-013 SHALL have port fill  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag: a match was dropped.
REQ-015 SHALL have port match_cnt  output  CNT_W  saturating count of all matches.

Function
REQ-016 SHALL keep a position counter pos that increments by 1 on each cycle with bit_en=1 and wraps from 2^POS_W-1 to 0.
REQ-017 SHALL treat tick as valid only when bit_en=1 in the same cycle; tick with bit_en=0 SHALL be ignored.
REQ-018 SHALL define a match event as tick=1 with bit_en=1; the logged value SHALL be pos before its increment, i.e. the index of the final '1' of 1101.
REQ-019 SHALL push the logged value when a match event occurs and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 SHALL pop when rd_en=1 and rd_valid=1; rd_en with an empty FIFO SHALL be ignored with no state change.
REQ-021 SHALL update rd_data one cycle after a pop to show the next entry; rd_data SHALL be stable while rd_valid=1 and no pop occurs.
REQ-022 SHALL handle a simultaneous push and pop as follows: fill unchanged, order preserved; when the FIFO is empty, only the push takes effect.
REQ-023 SHALL handle a match event with full=1 and no pop as follows: entry dropped, overflow set to 1 and held until clr or rst.
REQ-024 SHALL increment match_cnt on every match event, including dropped events, and saturate at 2^CNT_W-1.
REQ-025 SHALL derive full, rd_valid and fill from registered pointers with no combinational path from rd_en or tick.
REQ-026 SHALL, on clr=1: set pos, fill, pointers, overflow and match_cnt to 0 next cycle; clr SHALL take priority over a same-cycle push, pop or pos increment.

Reset
REQ-027 SHALL, on rst=1, immediately and asynchronously force pos=0, FIFO empty, rd_valid=0, full=0, fill=0, overflow=0, match_cnt=0.
REQ-028 SHALL drive rd_data to 0 in reset; FIFO storage contents need not be cleared.
REQ-029 SHALL discard a match event coincident with rst deassertion only if it violates setup; normal operation SHALL resume on the first clock edge after rst falls.

Verification
REQ-030 SHALL be covered by: bit_en=1 with stream 1101 from reset, tick on 4th bit -> rd_data=3, rd_valid=1, match_cnt=1.
REQ-031 SHALL be covered by: stream 1101101 -> entries 3 then 6, fill=2; two pops -> rd_valid=0.
REQ-032 SHALL be covered by: 5 matches with no pops, DEPTH=4 -> full=1, fill=4, overflow=1, match_cnt=5, 5th position absent.
REQ-033 SHALL be covered by: full FIFO with match and rd_en in the same cycle -> fill=4, overflow=0, new entry at tail.
REQ-034 SHALL be covered by: matches at pos 255 and at 2 after wrap -> entries 255, 2; match_cnt saturates at 255 after 300 matches with pops.
REQ-035 SHALL be covered by: rst asserted mid-stream with fill=2 -> rd_valid=0 and match_cnt=0 without a clock edge; clr with push -> fill=0.

Source files
------------

// File: rtl/match_event_logger.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | match_event_logger: logs 1101 match positions into a FWFT FIFO, with counters |
// | Rev 1.0                                                                         |
// +-----------------------------------------------------------------------------+
module match_event_logger #(
  parameter int POS_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     bit_en,
  input  logic                     tick,
  input  logic                     rd_en,
  output logic [POS_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

  logic [POS_W-1:0] pos;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [POS_W-1:0] mem [DEPTH];

  logic match;
  logic pop;
  logic push;
  logic drop;

  // Status flags come only from registered pointers, never from rd_en or tick.
  assign fill     = wr_ptr - rd_ptr;
  assign full     = (fill == C_FULL_LVL);
  assign rd_valid = (fill != '0);

  assign match = bit_en & tick;
  assign pop   = rd_en & rd_valid;
  assign push  = match & (~full | pop);
  assign drop  = match & full & ~pop;

  // Gating by rd_valid makes rd_data read 0 in reset without clearing storage.
  assign rd_data = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // When full with a same-cycle pop, the write slot equals the departing head.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr[AW-1:0]] <= pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      pos       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (bit_en) begin
        pos <= pos + POS_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_match_event_logger.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_match_event_logger: scoreboard bench for match_event_logger               |
// | Rev 1.0                                                                        |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_match_event_logger;

  localparam int POS_W   = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              bit_en = 1'b0;
  logic              tick = 1'b0;
  logic              rd_en = 1'b0;
  logic [POS_W-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic [$clog2(DEPTH):0] fill;
  logic              overflow;
  logic [CNT_W-1:0]  match_cnt;

  match_event_logger #(.POS_W(POS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bit_en(bit_en), .tick(tick), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .fill(fill),
    .overflow(overflow), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [POS_W-1:0] exp_q [$];
  logic [POS_W-1:0] m_pos;
  logic             m_ovf;
  int               m_cnt;
  logic [3:0]       sh;

  task automatic model_clear();
    exp_q.delete();
    m_pos = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
    sh    = '0;
  endtask

  // One clock: model update, scoreboard pop on a real pop, then the edge.
  task automatic cycle(input logic be, input logic tk, input logic re, input logic cl);
    logic [POS_W-1:0] head;
    bit m_pop;
    bit m_full;
    bit_en = be; tick = tk; rd_en = re; clr = cl;
    m_pop  = re && (exp_q.size() > 0) && !cl;
    m_full = (exp_q.size() == DEPTH);
    if (m_pop) begin
      head = exp_q.pop_front();
      vectors++;
      if (rd_data !== head) begin
        miscompares++;
        $display("FAIL pop_data: got %0d expected %0d", rd_data, head);
      end
    end
    if (cl) begin
      model_clear();
    end else begin
      if (be && tk) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_full || m_pop) exp_q.push_back(m_pos);
        else m_ovf = 1'b1;
      end
      if (be) m_pos++;
    end
    @(posedge clk); #1;
    bit_en = 1'b0; tick = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sh = {sh[2:0], b};
    cycle(1'b1, (sh == 4'b1101), 1'b0, 1'b0);
  endtask

  task automatic send_stream(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (exp_q.size() != 0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: rd_valid %0b left %0d expected empty", rd_valid, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
    if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b expected 0", full); end
    if (fill !== '0) begin miscompares++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    if (match_cnt !== '0) begin miscompares++; $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt); end
    if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
  endtask

  task automatic test_single();
    do_reset();
    send_stream(16'b1101, 4);
    vectors += 3;
    if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL single_rd_valid: got %0b expected 1", rd_valid); end
    if (rd_data !== 8'd3) begin miscompares++; $display("FAIL single_rd_data: got %0d expected 3", rd_data); end
    if (match_cnt !== 8'd1) begin miscompares++; $display("FAIL single_match_cnt: got %0d expected 1", match_cnt); end
    drain();
  endtask

  task automatic test_two();
    do_reset();
    send_stream(16'b1101101, 7);
    vectors += 2;
    if (fill !== 3'd2) begin miscompares++; $display("FAIL two_fill: got %0d expected 2", fill); end
    if (rd_data !== 8'd3) begin miscompares++; $display("FAIL two_head: got %0d expected 3", rd_data); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rd_data !== 8'd6) begin miscompares++; $display("FAIL two_second: got %0d expected 6", rd_data); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL two_empty: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    vectors += 4;
    if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %0b expected 1", full); end
    if (fill !== 3'd4) begin miscompares++; $display("FAIL ovf_fill: got %0d expected 4", fill); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    if (match_cnt !== 8'd5) begin miscompares++; $display("FAIL ovf_match_cnt: got %0d expected 5", match_cnt); end
    drain();
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    vectors += 3;
    if (fill !== 3'd4) begin miscompares++; $display("FAIL pp_fill: got %0d expected 4", fill); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_overflow: got %0b expected 0", overflow); end
    if (rd_data !== 8'd1) begin miscompares++; $display("FAIL pp_head: got %0d expected 1", rd_data); end
    drain();
  endtask

  task automatic test_ignored();
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    vectors += 2;
    if (match_cnt !== 8'd1) begin miscompares++; $display("FAIL ign_tick_cnt: got %0d expected 1", match_cnt); end
    if (fill !== 3'd1) begin miscompares++; $display("FAIL ign_tick_fill: got %0d expected 1", fill); end
    drain();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (fill !== '0) begin miscompares++; $display("FAIL ign_empty_pop: got %0d expected 0", fill); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rd_data !== 8'd1) begin miscompares++; $display("FAIL ign_pos_hold: got %0d expected 1", rd_data); end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    vectors += 2;
    if (rd_data !== 8'd255) begin miscompares++; $display("FAIL wrap_head: got %0d expected 255", rd_data); end
    if (fill !== 3'd2) begin miscompares++; $display("FAIL wrap_fill: got %0d expected 2", fill); end
    drain();
    for (int i = 0; i < 298; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    vectors += 2;
    if (match_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_sat_cnt: got %0d expected 255", match_cnt); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_overflow: got %0b expected 0", overflow); end
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    send_stream(16'b1101101, 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors += 4;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL arst_rd_valid: got %0b expected 0", rd_valid); end
    if (match_cnt !== '0) begin miscompares++; $display("FAIL arst_match_cnt: got %0d expected 0", match_cnt); end
    if (fill !== '0) begin miscompares++; $display("FAIL arst_fill: got %0d expected 0", fill); end
    if (rd_data !== '0) begin miscompares++; $display("FAIL arst_rd_data: got %0d expected 0", rd_data); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
    send_stream(16'b1101, 4);
    drain();
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    vectors += 4;
    if (fill !== '0) begin miscompares++; $display("FAIL clr_fill: got %0d expected 0", fill); end
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL clr_rd_valid: got %0b expected 0", rd_valid); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow: got %0b expected 0", overflow); end
    if (match_cnt !== '0) begin miscompares++; $display("FAIL clr_match_cnt: got %0d expected 0", match_cnt); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rd_data !== 8'd0) begin miscompares++; $display("FAIL clr_pos: got %0d expected 0", rd_data); end
    drain();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_two();
    test_overflow();
    test_push_pop_full();
    test_ignored();
    test_wrap();
    test_async_reset();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
